// File: rtl/dm_arb_pkg.sv
// ============================================================================
//  Module      : dm_arb_pkg
//  Description : Shared types and constants for the data-memory port arbiter.
//                Holds the arbiter FSM state encoding, the coprocessor
//                operation encoding and the doubleword-to-byte address shift.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dm_arb_pkg;

  // Arbiter FSM states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } dm_arb_state_t;

  // Latched coprocessor operation
  typedef enum logic {
    COP_RD = 1'b0,
    COP_WR = 1'b1
  } cop_op_t;

  // Coprocessor addresses are doubleword indices; shift to get a byte address.
  localparam int COP_ADDR_SHIFT = 3;

endpackage : dm_arb_pkg

`default_nettype wire

// File: rtl/dm_arb_starve_cnt.sv
// ============================================================================
//  Module      : dm_arb_starve_cnt
//  Description : Starvation counter for a pending coprocessor request. Counts
//                the cycles the request has been blocked by the core and
//                flags a forced grant once MAX_WAIT blocked cycles elapsed.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in  1 : system clock
//    reset   in  1 : asynchronous, active-high reset
//    clear   in  1 : restart the count (entry into the waiting state)
//    inc     in  1 : one more blocked cycle
//    forced  out 1 : count has reached MAX_WAIT, grant must be forced
// ============================================================================
`default_nettype none

module dm_arb_starve_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic forced
);

  localparam int             CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (clear) begin
      r_wait_cnt <= '0;
    end else if (inc && (r_wait_cnt != MAX_CNT)) begin
      // Saturate so the flag can never wrap away if inc is misused.
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  assign forced = (r_wait_cnt == MAX_CNT);

endmodule : dm_arb_starve_cnt

`default_nettype wire

// File: rtl/dm_port_arbiter.sv
// ============================================================================
//  Module      : dm_port_arbiter
//  Description : Shares the single synchronous data-memory port between the
//                core data interface (zero-latency priority) and the
//                coprocessor PIO debug access. Coprocessor requests are
//                edge-triggered from the PIO levels and finish with a
//                4-phase done handshake; a starvation counter forces a
//                one-cycle core stall so the coprocessor is always served.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, reset                : clock, asynchronous active-high reset
//    DM_addr/DM_writeData      : core byte address / write data
//    DM_writeEnable/readEnable : core access requests
//    DM_readData               : core read data (memory data, 1 cycle later)
//    core_stall                : core access not performed this cycle
//    cop_addr                  : coprocessor doubleword index
//    cop_we/cop_re             : coprocessor request levels
//    cop_wdata/cop_rdata       : coprocessor write data / registered read data
//    cop_done                  : coprocessor access complete
//    mem_addr/wdata/we/re      : memory port
//    mem_rdata                 : memory read data, valid 1 cycle after mem_re
// ============================================================================
`default_nettype none

module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int N        = 64,
  parameter int AW       = 15,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  // core data interface
  input  logic [N-1:0]  DM_addr,
  input  logic [N-1:0]  DM_writeData,
  input  logic          DM_writeEnable,
  input  logic          DM_readEnable,
  output logic [N-1:0]  DM_readData,
  output logic          core_stall,
  // coprocessor PIO interface
  input  logic [AW-1:0] cop_addr,
  input  logic          cop_we,
  input  logic          cop_re,
  input  logic [N-1:0]  cop_wdata,
  output logic [N-1:0]  cop_rdata,
  output logic          cop_done,
  // memory port
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [N-1:0]  mem_rdata
);

  localparam int PADW = N - AW - COP_ADDR_SHIFT;

  dm_arb_state_t r_state;
  dm_arb_state_t w_next_state;

  logic          r_prev;
  logic          r_pend;
  logic [AW-1:0] r_cop_addr;
  logic [N-1:0]  r_cop_wdata;
  cop_op_t       r_cop_op;
  logic          r_rd_owner_cop;
  logic [N-1:0]  r_cop_rdata;

  logic          w_core_act;
  logic          w_cop_req;
  logic          w_cop_edge;
  logic          w_capture;
  logic          w_forced;
  logic          w_grant;
  logic [N-1:0]  w_cop_byte_addr;

  assign w_core_act = DM_writeEnable | DM_readEnable;
  assign w_cop_req  = cop_we | cop_re;
  assign w_cop_edge = w_cop_req & ~r_prev;
  // Edges outside IDLE are deliberately dropped: one access in flight at a time.
  assign w_capture  = (r_state == IDLE) && w_cop_edge;

  // The port goes to the coprocessor when the core is idle or the wait expired.
  assign w_grant = (r_state == WAIT) && r_pend && (!w_core_act || w_forced);

  assign w_cop_byte_addr = {{PADW{1'b0}}, r_cop_addr, {COP_ADDR_SHIFT{1'b0}}};

  dm_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_capture),
    .inc    ((r_state == WAIT) && w_core_act && !w_forced),
    .forced (w_forced)
  );

  // --------------------------------------------------------------------------
  // Request capture and read-data routing registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // prev starts high so a level held through reset is not seen as an edge
      r_prev         <= 1'b1;
      r_pend         <= 1'b0;
      r_cop_addr     <= '0;
      r_cop_wdata    <= '0;
      r_cop_op       <= COP_RD;
      r_rd_owner_cop <= 1'b0;
      r_cop_rdata    <= '0;
    end else begin
      r_prev <= w_cop_req;
      if (w_capture) begin
        r_pend      <= 1'b1;
        r_cop_addr  <= cop_addr;
        r_cop_wdata <= cop_wdata;
        // simultaneous we/re resolves to a write
        r_cop_op    <= cop_we ? COP_WR : COP_RD;
      end else if (w_grant) begin
        r_pend <= 1'b0;
      end
      // Remember who issued this cycle's read so next cycle's data is routed.
      r_rd_owner_cop <= w_grant && (r_cop_op == COP_RD);
      if (r_rd_owner_cop) begin
        r_cop_rdata <= mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_cop_edge) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (w_grant) begin
          w_next_state = (r_cop_op == COP_RD) ? RDWAIT : DONE;
        end
      end
      RDWAIT: begin
        w_next_state = DONE;
      end
      DONE: begin
        // 4-phase handshake: wait for software to release the request level
        if (!w_cop_req) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / memory port mux
  // --------------------------------------------------------------------------
  always_comb begin
    mem_addr   = DM_addr;
    mem_wdata  = DM_writeData;
    mem_we     = DM_writeEnable;
    mem_re     = DM_readEnable & ~DM_writeEnable;
    core_stall = 1'b0;
    if (w_grant) begin
      mem_addr   = w_cop_byte_addr;
      mem_wdata  = r_cop_wdata;
      mem_we     = (r_cop_op == COP_WR);
      mem_re     = (r_cop_op == COP_RD);
      core_stall = w_core_act;
    end
  end

  assign cop_done    = (r_state == DONE);
  assign cop_rdata   = r_cop_rdata;
  // Only meaningful to the core when it owned the previous read.
  assign DM_readData = mem_rdata;

endmodule : dm_port_arbiter

`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
// ============================================================================
//  Module      : tb_dm_port_arbiter
//  Description : Directed self-checking bench for dm_port_arbiter with a
//                behavioural synchronous RAM. Expected values are pushed to a
//                scoreboard queue as stimulus is driven and popped when the
//                corresponding DUT output is sampled.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_port_arbiter;

  localparam int N  = 64;
  localparam int AW = 15;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  DM_addr = '0;
  logic [N-1:0]  DM_writeData = '0;
  logic          DM_writeEnable = 1'b0;
  logic          DM_readEnable = 1'b0;
  logic [N-1:0]  DM_readData;
  logic          core_stall;
  logic [AW-1:0] cop_addr = '0;
  logic          cop_we = 1'b0;
  logic          cop_re = 1'b0;
  logic [N-1:0]  cop_wdata = '0;
  logic [N-1:0]  cop_rdata;
  logic          cop_done;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [N-1:0]  mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  string        tag_q[$];
  logic [63:0]  exp_q[$];

  logic [63:0]  ram [0:255];

  dm_port_arbiter #(
    .N        (N),
    .AW       (AW),
    .MAX_WAIT (MW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .core_stall     (core_stall),
    .cop_addr       (cop_addr),
    .cop_we         (cop_we),
    .cop_re         (cop_re),
    .cop_wdata      (cop_wdata),
    .cop_rdata      (cop_rdata),
    .cop_done       (cop_done),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, one access per cycle, read data next cycle.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[10:3]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[10:3]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // ---------------- reset values ----------------
    #12;
    sb_push("rst done", 0); sb_push("rst rdata", 0); sb_push("rst stall", 0);
    sb_push("rst we", 0);   sb_push("rst re", 0);
    @(negedge clk);
    sb_check(64'(cop_done)); sb_check(cop_rdata); sb_check(64'(core_stall));
    sb_check(64'(mem_we));   sb_check(64'(mem_re));
    tick();
    reset = 1'b0;
    tick();

    // ---------------- core-only write/read ----------------
    DM_writeEnable = 1'b1; DM_addr = 64'd0; DM_writeData = 64'hA5;
    sb_push("core wr we", 1); sb_push("core wr addr", 0); sb_push("core wr data", 64'hA5);
    sb_push("core wr stall", 0);
    @(negedge clk);
    sb_check(64'(mem_we)); sb_check(mem_addr); sb_check(mem_wdata); sb_check(64'(core_stall));
    tick();
    DM_writeEnable = 1'b0; DM_readEnable = 1'b1;
    sb_push("core rd re", 1); sb_push("core rd we", 0);
    @(negedge clk);
    sb_check(64'(mem_re)); sb_check(64'(mem_we));
    tick();
    DM_readEnable = 1'b0;
    sb_push("core rd data", 64'hA5); sb_push("core rd stall", 0);
    @(negedge clk);
    sb_check(DM_readData); sb_check(64'(core_stall));

    // ---------------- coprocessor write, core idle ----------------
    tick();
    cop_addr = 15'd2; cop_wdata = 64'h1234; cop_we = 1'b1;   // cycle t
    sb_push("cw t we", 0);
    @(negedge clk);
    sb_check(64'(mem_we));
    tick();                                                  // t+1
    sb_push("cw t1 we", 1); sb_push("cw t1 addr", 16); sb_push("cw t1 data", 64'h1234);
    sb_push("cw t1 done", 0); sb_push("cw t1 stall", 0);
    @(negedge clk);
    sb_check(64'(mem_we)); sb_check(mem_addr); sb_check(mem_wdata);
    sb_check(64'(cop_done)); sb_check(64'(core_stall));
    tick();                                                  // t+2
    sb_push("cw t2 done", 1); sb_push("cw t2 we", 0);
    @(negedge clk);
    sb_check(64'(cop_done)); sb_check(64'(mem_we));
    tick();                                                  // t+3 held
    sb_push("cw t3 hold", 1);
    @(negedge clk);
    sb_check(64'(cop_done));
    tick();
    cop_we = 1'b0;
    sb_push("cw rel done", 1);
    @(negedge clk);
    sb_check(64'(cop_done));
    tick();
    sb_push("cw idle done", 0);
    @(negedge clk);
    sb_check(64'(cop_done));

    // ---------------- coprocessor read ----------------
    tick();
    DM_writeEnable = 1'b1; DM_addr = 64'd16; DM_writeData = 64'hBEEF;
    tick();
    DM_writeEnable = 1'b0;
    cop_addr = 15'd2; cop_re = 1'b1;                         // cycle t
    tick();                                                  // t+1
    sb_push("cr t1 re", 1); sb_push("cr t1 addr", 16); sb_push("cr t1 we", 0);
    @(negedge clk);
    sb_check(64'(mem_re)); sb_check(mem_addr); sb_check(64'(mem_we));
    tick();                                                  // t+2: core reads
    DM_readEnable = 1'b1; DM_addr = 64'd0;
    sb_push("cr t2 re", 1); sb_push("cr t2 addr", 0); sb_push("cr t2 stall", 0);
    sb_push("cr t2 done", 0);
    @(negedge clk);
    sb_check(64'(mem_re)); sb_check(mem_addr); sb_check(64'(core_stall));
    sb_check(64'(cop_done));
    tick();                                                  // t+3
    DM_readEnable = 1'b0; cop_re = 1'b0;
    sb_push("cr t3 done", 1); sb_push("cr t3 rdata", 64'hBEEF); sb_push("cr t3 core", 64'hA5);
    @(negedge clk);
    sb_check(64'(cop_done)); sb_check(cop_rdata); sb_check(DM_readData);
    tick();
    sb_push("cr idle done", 0);
    @(negedge clk);
    sb_check(64'(cop_done));

    // ---------------- starvation, continuous core reads ----------------
    tick();
    DM_readEnable = 1'b1; DM_addr = 64'd0;
    cop_addr = 15'd3; cop_wdata = 64'h77; cop_we = 1'b1;     // cycle t
    sb_push("sv t stall", 0);
    @(negedge clk);
    sb_check(64'(core_stall));
    for (int k = 1; k <= 6; k++) begin
      tick();
      sb_push($sformatf("sv t%0d stall", k), 64'(k == 5));
      sb_push($sformatf("sv t%0d we", k), 64'(k == 5));
      sb_push($sformatf("sv t%0d re", k), 64'(k != 5));
      sb_push($sformatf("sv t%0d addr", k), (k == 5) ? 64'd24 : 64'd0);
      sb_push($sformatf("sv t%0d done", k), 64'(k == 6));
      @(negedge clk);
      sb_check(64'(core_stall)); sb_check(64'(mem_we)); sb_check(64'(mem_re));
      sb_check(mem_addr); sb_check(64'(cop_done));
    end
    tick();                                                  // t+7
    DM_readEnable = 1'b0; cop_we = 1'b0;
    sb_push("sv t7 core", 64'hA5);
    @(negedge clk);
    sb_check(DM_readData);
    tick();
    sb_push("sv idle done", 0);
    @(negedge clk);
    sb_check(64'(cop_done));

    // ---------------- reset during WAIT with cop_we held ----------------
    tick();
    DM_readEnable = 1'b1; DM_addr = 64'd0;
    cop_addr = 15'd5; cop_wdata = 64'h99; cop_we = 1'b1;     // cycle t
    tick();                                                  // t+1 WAIT
    tick();                                                  // t+2 WAIT
    reset = 1'b1;
    tick();
    reset = 1'b0; DM_readEnable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb_push($sformatf("rw c%0d we", k), 0);
      sb_push($sformatf("rw c%0d done", k), 0);
      @(negedge clk);
      sb_check(64'(mem_we)); sb_check(64'(cop_done));
      tick();
    end
    cop_we = 1'b0;
    tick();
    cop_we = 1'b1;                                           // new edge at t'
    tick();                                                  // t'+1
    sb_push("rw new we", 1); sb_push("rw new addr", 40); sb_push("rw new data", 64'h99);
    @(negedge clk);
    sb_check(64'(mem_we)); sb_check(mem_addr); sb_check(mem_wdata);
    tick();
    sb_push("rw new done", 1);
    @(negedge clk);
    sb_check(64'(cop_done));
    tick();
    cop_we = 1'b0;
    tick();

    // ---------------- simultaneous we and re ----------------
    cop_addr = 15'd4; cop_wdata = 64'h55; cop_we = 1'b1; cop_re = 1'b1;
    tick();
    sb_push("both we", 1); sb_push("both re", 0); sb_push("both addr", 32);
    @(negedge clk);
    sb_check(64'(mem_we)); sb_check(64'(mem_re)); sb_check(mem_addr);
    tick();
    sb_push("both done", 1); sb_push("both t2 re", 0);
    @(negedge clk);
    sb_check(64'(cop_done)); sb_check(64'(mem_re));
    tick();
    cop_we = 1'b0; cop_re = 1'b0;
    tick();
    DM_readEnable = 1'b1; DM_addr = 64'd32;
    tick();
    DM_readEnable = 1'b0;
    sb_push("both mem", 64'h55);
    @(negedge clk);
    sb_check(DM_readData);

    // ---------------- wrap-up ----------------
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dm_port_arbiter

`default_nettype wire
